gus_uart_core: RTL and testbench



---
 rtl/gus_uart_pkg.sv | 23 ++
 rtl/gus_uart_if.sv | 31 +++
 rtl/gus_uart_bit_timer.sv | 30 +++
 rtl/gus_uart_core.sv | 196 +++++++++++++++++++
 tb/tb_gus_uart_core.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/gus_uart_pkg.sv
// Shared definitions for the GUS16 console UART: frame size and the TX/RX FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gus_uart_pkg;

  localparam int BITS = 8;                // data bits per frame, LSB first
  localparam int BCW  = $clog2(BITS);     // width of the data-bit index

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/gus_uart_if.sv
// CPU-side register/strobe bundle of the console UART (write data, read ack, status flags).
// Latency: wires only; all timing lives in gus_uart_core.
// Backpressure: CPU must only pulse wr while txrdy=1; writes while busy are dropped.
// Ports: d/wr/nstop = transmit byte, strobe and stop-bit count; rd = receive acknowledge;
//        q/rxvalid = received byte and its valid flag; txrdy = transmitter idle;
//        rxoverr/rxframeer = sticky receive error flags.
interface gus_uart_if;

  logic [7:0] d;
  logic       wr;
  logic       rd;
  logic       nstop;
  logic [7:0] q;
  logic       rxvalid;
  logic       txrdy;
  logic       rxoverr;
  logic       rxframeer;

  // CPU / I/O decoder side
  modport master (
    output d, wr, rd, nstop,
    input  q, rxvalid, txrdy, rxoverr, rxframeer
  );

  // UART side
  modport slave (
    input  d, wr, rd, nstop,
    output q, rxvalid, txrdy, rxoverr, rxframeer
  );

endinterface

// File: rtl/gus_uart_bit_timer.sv
// Loadable down-counter that flags the cycle in which it has reached zero.
// Latency: tick is high in the cycle after load_val+1 running cycles; load takes effect next edge.
// Backpressure: none; the owner reloads on tick to keep a periodic bit clock.
// Ports: load/load_val = (re)start the count; run = count enable; tick = count is zero while running.
module gus_uart_bit_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/gus_uart_core.sv
// 8N1/8N2 UART transceiver: CPU byte writes serialised on txd, rxd deserialised into q.
// Latency: txd start bit one edge after wr is sampled; rxvalid ~9.5 bit times after the rxd start edge.
// Backpressure: wr is only accepted while txrdy=1; an unread byte overwritten by a new one sets rxoverr.
// Ports: clk/rst_n = clock and async active-low reset; bus = CPU-side strobes and status;
//        txd = serial output (idle high); rxd = asynchronous serial input.
module gus_uart_core
  import gus_uart_pkg::*;
#(
  parameter int DIVIDER = 52
) (
  input  logic       clk,
  input  logic       rst_n,
  gus_uart_if.slave  bus,
  output logic       txd,
  input  logic       rxd
);

  localparam int CW = $clog2(DIVIDER);
  // Timers count load value down to zero inclusive, so a full bit reloads DIVIDER-1.
  localparam logic [CW-1:0] FULL_BIT = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(DIVIDER / 2);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS - 1);

  // ---------------------------------------------------------------- transmitter
  tx_state_t       tx_state;
  logic [BITS-1:0] tx_shift;
  logic [BCW-1:0]  tx_bit;
  logic            tx_two_stop;
  logic            tx_stop2;
  logic            txd_r;
  logic            txrdy_r;
  logic            tx_tick;
  logic            tx_load;

  assign tx_load = ((tx_state == TX_IDLE) && bus.wr) || tx_tick;

  gus_uart_bit_timer #(.W(CW)) u_tx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val (FULL_BIT),
    .run      (tx_state != TX_IDLE),
    .tick     (tx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_shift    <= '0;
      tx_bit      <= '0;
      tx_two_stop <= 1'b0;
      tx_stop2    <= 1'b0;
      txd_r       <= 1'b1;
      txrdy_r     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.wr) begin
            tx_shift    <= bus.d;
            tx_two_stop <= bus.nstop;   // stop count frozen for the whole frame
            tx_stop2    <= 1'b0;
            txd_r       <= 1'b0;
            txrdy_r     <= 1'b0;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            txd_r    <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit == LAST_BIT) begin
              txd_r    <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd_r    <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + BCW'(1);
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_two_stop && !tx_stop2) begin
              tx_stop2 <= 1'b1;
            end else begin
              txrdy_r  <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd       = txd_r;
  assign bus.txrdy = txrdy_r;

  // ---------------------------------------------------------------- receiver
  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_prev;
  logic            rx_fall;
  logic [BITS-1:0] rx_shift;
  logic [BCW-1:0]  rx_bit;
  logic [7:0]      q_r;
  logic            rxvalid_r, rxoverr_r, rxframeer_r;
  logic            rx_tick;
  logic            rx_load;

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_load = ((rx_state == RX_IDLE) && rx_fall) || rx_tick;

  // First load after the start edge lands the samples near bit centres.
  gus_uart_bit_timer #(.W(CW)) u_rx_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rx_load),
    .load_val ((rx_state == RX_IDLE) ? HALF_BIT : FULL_BIT),
    .run      (rx_state != RX_IDLE),
    .tick     (rx_tick)
  );

  // Synchroniser resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      rx_shift    <= '0;
      rx_bit      <= '0;
      q_r         <= '0;
      rxvalid_r   <= 1'b0;
      rxoverr_r   <= 1'b0;
      rxframeer_r <= 1'b0;
    end else begin
      if (bus.rd) begin
        rxvalid_r   <= 1'b0;
        rxoverr_r   <= 1'b0;
        rxframeer_r <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tick) begin
            rx_bit   <= '0;
            // Line back high at mid start bit: noise, not a frame.
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + BCW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            // Completion overrides a same-cycle rd: the new byte is kept valid,
            // and rd only suppresses the overrun and clears older errors.
            q_r         <= rx_shift;
            rxvalid_r   <= 1'b1;
            rxoverr_r   <= !bus.rd && (rxvalid_r || rxoverr_r);
            rxframeer_r <= !rx_s2 || (rxframeer_r && !bus.rd);
            rx_state    <= RX_IDLE;   // leave mid stop bit to catch the next start edge
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.q         = q_r;
  assign bus.rxvalid   = rxvalid_r;
  assign bus.rxoverr   = rxoverr_r;
  assign bus.rxframeer = rxframeer_r;

endmodule

// File: tb/tb_gus_uart_core.sv
// Directed self-checking bench for gus_uart_core at DIVIDER=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// Ends with a single summary line of compared/mismatched counts.
module tb_gus_uart_core;

  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;
  logic rxd;
  logic rxd_man = 1'b1;
  logic loop = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic wave [0:199];

  assign rxd = loop ? txd : rxd_man;

  gus_uart_if bus ();

  gus_uart_core #(.DIVIDER(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .txd   (txd),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] b, input logic ns);
    @(negedge clk);
    bus.d = b; bus.nstop = ns; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // Sends one frame, recording txd each cycle; low = cycles txrdy stayed 0 (-1 if never released).
  task automatic tx_frame(input logic [7:0] b, input logic ns, input bit busy_wr, output int low);
    cpu_write(b, ns);
    low = -1;
    for (int n = 0; n < 200; n++) begin
      if (bus.txrdy) begin
        low = n;
        break;
      end
      wave[n] = txd;
      if (busy_wr && n == 20) begin
        bus.d = 8'hFF; bus.nstop = 1'b1; bus.wr = 1'b1;
      end
      if (busy_wr && n == 21) bus.wr = 1'b0;
      @(negedge clk);
    end
  endtask

  // Every cycle of each bit window must carry the expected line level.
  task automatic chk_wave(input string tag, input logic [7:0] b, input int nbits);
    logic [10:0] fr;
    logic        ok;
    fr = {2'b11, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ok = 1'b1;
      for (int j = 0; j < DIV; j++)
        if (wave[i*DIV + j] !== fr[i]) ok = 1'b0;
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, ok ? fr[i] : ~fr[i]}, {31'd0, fr[i]});
    end
  endtask

  task automatic wait_rxvalid(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      if (bus.rxvalid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_txrdy(input string tag);
    int seen;
    seen = 0;
    for (int n = 0; n < 300; n++) begin
      if (bus.txrdy) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, seen, 1);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stopbit);
    logic [9:0] fr;
    fr = {stopbit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_man = fr[i];
      repeat (DIV) @(negedge clk);
    end
    rxd_man = 1'b1;
  endtask

  initial begin
    int low;
    int lat;

    bus.d = 8'h00; bus.wr = 1'b0; bus.rd = 1'b0; bus.nstop = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_txrdy", bus.txrdy, 1);
    chk("rst_rxvalid", bus.rxvalid, 0);
    chk("rst_q", bus.q, 8'h00);
    chk("rst_rxoverr", bus.rxoverr, 0);
    chk("rst_rxframeer", bus.rxframeer, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, one stop bit: line 0,1,0,1,0,0,1,0,1,1 and 80 busy cycles
    tx_frame(8'hA5, 1'b0, 1'b0, low);
    chk("tx_a5_1stop_busy", low, 80);
    chk_wave("tx_a5_1stop", 8'hA5, 10);

    // Same byte, two stop bits: 88 busy cycles
    tx_frame(8'hA5, 1'b1, 1'b0, low);
    chk("tx_a5_2stop_busy", low, 88);
    chk_wave("tx_a5_2stop", 8'hA5, 11);

    // Write 0xFF (with nstop=1) mid-frame: must not disturb the frame
    tx_frame(8'hA5, 1'b0, 1'b1, low);
    chk("tx_busy_wr_busy", low, 80);
    chk_wave("tx_busy_wr", 8'hA5, 10);
    repeat (3) @(negedge clk);
    chk("tx_busy_wr_idle_txd", txd, 1);
    chk("tx_busy_wr_idle_txrdy", bus.txrdy, 1);

    // Loopback 0x3C
    loop = 1'b1;
    cpu_write(8'h3C, 1'b0);
    wait_rxvalid(lat);
    chk("lb_latency_in_window", {31'd0, (lat >= 79 && lat <= 81)}, 1);
    chk("lb_q", bus.q, 8'h3C);
    chk("lb_rxoverr", bus.rxoverr, 0);
    chk("lb_rxframeer", bus.rxframeer, 0);
    wait_txrdy("lb_txrdy_back");
    repeat (5) @(negedge clk);
    chk("lb_rxvalid_held", bus.rxvalid, 1);
    chk("lb_q_held", bus.q, 8'h3C);
    rd_pulse();
    chk("lb_rd_clears", bus.rxvalid, 0);

    // 0x11 then 0x22 with no rd in between: overrun
    cpu_write(8'h11, 1'b0);
    wait_txrdy("ovr_tx1_done");
    cpu_write(8'h22, 1'b0);
    wait_txrdy("ovr_tx2_done");
    repeat (10) @(negedge clk);
    chk("ovr_q", bus.q, 8'h22);
    chk("ovr_rxvalid", bus.rxvalid, 1);
    chk("ovr_rxoverr", bus.rxoverr, 1);
    chk("ovr_rxframeer", bus.rxframeer, 0);
    rd_pulse();
    chk("ovr_rd_rxvalid", bus.rxvalid, 0);
    chk("ovr_rd_rxoverr", bus.rxoverr, 0);
    chk("ovr_rd_rxframeer", bus.rxframeer, 0);

    // Frame with a 0 stop bit
    loop = 1'b0;
    repeat (4) @(negedge clk);
    send_raw(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    chk("fe_rxframeer", bus.rxframeer, 1);
    chk("fe_rxvalid", bus.rxvalid, 1);
    chk("fe_q", bus.q, 8'h5A);
    chk("fe_rxoverr", bus.rxoverr, 0);
    rd_pulse();
    chk("fe_rd_rxframeer", bus.rxframeer, 0);

    // 2-cycle low glitch on rxd
    @(negedge clk);
    rxd_man = 1'b0;
    repeat (2) @(negedge clk);
    rxd_man = 1'b1;
    repeat (120) @(negedge clk);
    chk("glitch_rxvalid", bus.rxvalid, 0);
    chk("glitch_rxframeer", bus.rxframeer, 0);
    chk("glitch_q_kept", bus.q, 8'h5A);

    // Reset in the middle of a transmit frame
    cpu_write(8'h00, 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst_txd_before", txd, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_txrdy", bus.txrdy, 1);
    chk("midrst_q", bus.q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
